// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Target-side responder for the single-cycle core's data SRAM port.
//   Each word access decodes to either a word-addressed data RAM or a small
//   MMIO bank (LED, switches, free-running timer, scratch, 4-entry TX FIFO).
//   Reads are combinational, with no side effects. Writes commit on the next
//   rising edge of clk.
//
// Parameters
//   RAM_AW   RAM word-address width; the RAM holds 2**RAM_AW words
//   MMIO_HI  value of addr[31:16] that selects the MMIO bank
//
// Ports
//   clk              clock
//   reset            synchronous, active-high reset
//   data_sram_we     full-word write strobe
//   data_sram_addr   byte address; bits [1:0] are ignored
//   data_sram_wdata  write data
//   data_sram_rdata  combinational read data for the current address
//   switch           board switch inputs
//   led              LED register
//   tx_valid         TX FIFO head is valid
//   tx_data          TX FIFO head byte; 0 when the FIFO is empty
//   tx_ready         consumer accepts the head when tx_valid & tx_ready
module data_sram_responder #(
    parameter int          RAM_AW  = 10,
    parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    // MMIO word offsets (addr[15:2])
    localparam logic [13:0] OFF_LED     = 14'h0000;
    localparam logic [13:0] OFF_SWITCH  = 14'h0001;
    localparam logic [13:0] OFF_TIMER   = 14'h0002;
    localparam logic [13:0] OFF_SCRATCH = 14'h0003;
    localparam logic [13:0] OFF_TXDATA  = 14'h0004;
    localparam logic [13:0] OFF_TXSTAT  = 14'h0005;

    logic [31:0] mem [0:(2**RAM_AW)-1];

    logic              mmio_sel;
    logic [13:0]       off_w;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr_lsbs;

    logic [31:0] timer_q;
    logic [31:0] scratch_q;
    logic [15:0] led_q;

    logic [7:0] fifo_mem [0:3];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [2:0] count;
    logic       ovf;

    logic wr_led, wr_timer, wr_scratch, wr_txstat, push_req;
    logic fifo_full, fifo_empty, pop, push, ovf_set;

    assign mmio_sel         = (data_sram_addr[31:16] == MMIO_HI);
    assign off_w            = data_sram_addr[15:2];
    assign ram_idx          = data_sram_addr[RAM_AW+1:2];
    assign unused_addr_lsbs = ^data_sram_addr[1:0];

    assign wr_led     = data_sram_we && mmio_sel && (off_w == OFF_LED);
    assign wr_timer   = data_sram_we && mmio_sel && (off_w == OFF_TIMER);
    assign wr_scratch = data_sram_we && mmio_sel && (off_w == OFF_SCRATCH);
    assign push_req   = data_sram_we && mmio_sel && (off_w == OFF_TXDATA);
    assign wr_txstat  = data_sram_we && mmio_sel && (off_w == OFF_TXSTAT);

    assign fifo_empty = (count == 3'd0);
    assign fifo_full  = (count == 3'd4);
    assign pop        = tx_valid && tx_ready;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;

    assign led      = led_q;
    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

    // RAM: asynchronous read, contents survive reset.
    always_ff @(posedge clk) begin
        if (data_sram_we && !mmio_sel) begin
            mem[ram_idx] <= data_sram_wdata;
        end
    end

    // FIFO storage needs no reset; tx_data is masked while empty.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr] <= data_sram_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q     <= '0;
            timer_q   <= '0;
            scratch_q <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
        end else begin
            if (wr_led) begin
                led_q <= data_sram_wdata[15:0];
            end
            // A timer write overrides that cycle's increment.
            if (wr_timer) begin
                timer_q <= data_sram_wdata;
            end else begin
                timer_q <= timer_q + 32'd1;
            end
            if (wr_scratch) begin
                scratch_q <= data_sram_wdata;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + 3'(push) - 3'(pop);
            // A dropped byte wins over a same-cycle clear.
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (wr_txstat) begin
                ovf <= 1'b0;
            end
        end
    end

    always_comb begin
        data_sram_rdata = '0;
        if (mmio_sel) begin
            case (off_w)
                OFF_LED:     data_sram_rdata = {16'h0000, led_q};
                OFF_SWITCH:  data_sram_rdata = {24'h000000, switch};
                OFF_TIMER:   data_sram_rdata = timer_q;
                OFF_SCRATCH: data_sram_rdata = scratch_q;
                OFF_TXDATA:  data_sram_rdata = {24'h000000, tx_data};
                OFF_TXSTAT:  data_sram_rdata = {26'h0, ovf, fifo_full, fifo_empty, count};
                default:     data_sram_rdata = '0;
            endcase
        end else begin
            data_sram_rdata = mem[ram_idx];
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch;
    logic [15:0] led;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

    data_sram_responder #(.RAM_AW(10), .MMIO_HI(16'hbfaf)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch          (switch),
        .led             (led),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] A_RAM     = 32'h1c000100;
    localparam logic [31:0] A_LED     = 32'hbfaf0000;
    localparam logic [31:0] A_SWITCH  = 32'hbfaf0004;
    localparam logic [31:0] A_TIMER   = 32'hbfaf0008;
    localparam logic [31:0] A_SCRATCH = 32'hbfaf000c;
    localparam logic [31:0] A_TXDATA  = 32'hbfaf0010;
    localparam logic [31:0] A_TXSTAT  = 32'hbfaf0014;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic [15:0] exp_led;
        logic        exp_valid;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ready, input logic chk_rd,
                       input logic [31:0] exp_rdata, input logic [15:0] exp_led,
                       input logic exp_valid, input logic [7:0] exp_data);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.ready = ready;
        v.chk_rd = chk_rd; v.exp_rdata = exp_rdata; v.exp_led = exp_led;
        v.exp_valid = exp_valid; v.exp_data = exp_data;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        data_sram_we    = we;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        #2;
    endtask

    initial begin
        reset = 1'b1; data_sram_we = 1'b0; data_sram_addr = '0; data_sram_wdata = '0;
        switch = 8'h3c; tx_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state and timer
        drive(1'b0, A_TIMER, '0);
        chk("timer_first", data_sram_rdata, 32'd0);
        chk("led_reset", {16'h0, led}, 32'h0);
        chk("txvalid_reset", {31'h0, tx_valid}, 32'h0);
        chk("txdata_reset", {24'h0, tx_data}, 32'h0);
        tick(); drive(1'b0, A_TIMER, '0);
        chk("timer_c1", data_sram_rdata, 32'd1);
        tick(); drive(1'b0, A_TIMER, '0);
        chk("timer_c2", data_sram_rdata, 32'd2);
        tick(); drive(1'b1, A_TIMER, 32'hfffffffe);
        chk("timer_rbw", data_sram_rdata, 32'd3);
        tick(); drive(1'b0, A_TIMER, '0);
        chk("timer_load", data_sram_rdata, 32'hfffffffe);
        tick(); drive(1'b0, A_TIMER, '0);
        chk("timer_max", data_sram_rdata, 32'hffffffff);
        tick(); drive(1'b0, A_TIMER, '0);
        chk("timer_wrap", data_sram_rdata, 32'h00000000);
        tick();

        //   name          we    addr                 wdata          rdy  chk   rdata          led      v  data
        add("ram_wr",      1'b1, A_RAM,               32'h12345678, 1'b0, 1'b0, 32'h0,        16'h0,    0, 8'h00);
        add("ram_rd",      1'b0, A_RAM,               32'h0,        1'b0, 1'b1, 32'h12345678, 16'h0,    0, 8'h00);
        add("ram_lsb",     1'b0, A_RAM + 32'd2,       32'h0,        1'b0, 1'b1, 32'h12345678, 16'h0,    0, 8'h00);
        add("ram_alias",   1'b0, A_RAM + 32'h1000,    32'h0,        1'b0, 1'b1, 32'h12345678, 16'h0,    0, 8'h00);
        add("led_wr",      1'b1, A_LED,               32'hffffa5a5, 1'b0, 1'b1, 32'h0,        16'h0,    0, 8'h00);
        add("led_rd",      1'b0, A_LED,               32'h0,        1'b0, 1'b1, 32'h0000a5a5, 16'ha5a5, 0, 8'h00);
        add("led_lsb",     1'b0, A_LED + 32'd3,       32'h0,        1'b0, 1'b1, 32'h0000a5a5, 16'ha5a5, 0, 8'h00);
        add("sw_rd",       1'b0, A_SWITCH,            32'h0,        1'b0, 1'b1, 32'h0000003c, 16'ha5a5, 0, 8'h00);
        add("sw_wr",       1'b1, A_SWITCH,            32'hffffffff, 1'b0, 1'b1, 32'h0000003c, 16'ha5a5, 0, 8'h00);
        add("sw_rd2",      1'b0, A_SWITCH,            32'h0,        1'b0, 1'b1, 32'h0000003c, 16'ha5a5, 0, 8'h00);
        add("scr_wr",      1'b1, A_SCRATCH,           32'hdeadbeef, 1'b0, 1'b1, 32'h0,        16'ha5a5, 0, 8'h00);
        add("scr_rd",      1'b0, A_SCRATCH,           32'h0,        1'b0, 1'b1, 32'hdeadbeef, 16'ha5a5, 0, 8'h00);
        add("hole_wr",     1'b1, 32'hbfaf0018,        32'h11111111, 1'b0, 1'b1, 32'h0,        16'ha5a5, 0, 8'h00);
        add("hole_rd",     1'b0, 32'hbfaf0018,        32'h0,        1'b0, 1'b1, 32'h0,        16'ha5a5, 0, 8'h00);
        add("stat_empty",  1'b0, A_TXSTAT,            32'h0,        1'b0, 1'b1, 32'h08,       16'ha5a5, 0, 8'h00);
        add("push41",      1'b1, A_TXDATA,            32'hffffff41, 1'b0, 1'b1, 32'h0,        16'ha5a5, 0, 8'h00);
        add("push42",      1'b1, A_TXDATA,            32'h42,       1'b0, 1'b1, 32'h41,       16'ha5a5, 1, 8'h41);
        add("push43",      1'b1, A_TXDATA,            32'h43,       1'b0, 1'b1, 32'h41,       16'ha5a5, 1, 8'h41);
        add("push44",      1'b1, A_TXDATA,            32'h44,       1'b0, 1'b1, 32'h41,       16'ha5a5, 1, 8'h41);
        add("stat_full",   1'b0, A_TXSTAT,            32'h0,        1'b0, 1'b1, 32'h14,       16'ha5a5, 1, 8'h41);
        add("push45_ovf",  1'b1, A_TXDATA,            32'h45,       1'b0, 1'b1, 32'h41,       16'ha5a5, 1, 8'h41);
        add("stat_ovf",    1'b0, A_TXSTAT,            32'h0,        1'b0, 1'b1, 32'h34,       16'ha5a5, 1, 8'h41);
        add("drain41",     1'b0, A_TXSTAT,            32'h0,        1'b1, 1'b1, 32'h34,       16'ha5a5, 1, 8'h41);
        add("drain42",     1'b0, A_TXSTAT,            32'h0,        1'b1, 1'b1, 32'h23,       16'ha5a5, 1, 8'h42);
        add("drain43",     1'b0, A_TXSTAT,            32'h0,        1'b1, 1'b1, 32'h22,       16'ha5a5, 1, 8'h43);
        add("drain44",     1'b0, A_TXSTAT,            32'h0,        1'b1, 1'b1, 32'h21,       16'ha5a5, 1, 8'h44);
        add("drained",     1'b0, A_TXSTAT,            32'h0,        1'b1, 1'b1, 32'h28,       16'ha5a5, 0, 8'h00);
        add("stat_clr",    1'b1, A_TXSTAT,            32'h0,        1'b0, 1'b1, 32'h28,       16'ha5a5, 0, 8'h00);
        add("stat_clred",  1'b0, A_TXSTAT,            32'h0,        1'b0, 1'b1, 32'h08,       16'ha5a5, 0, 8'h00);

        foreach (vecs[i]) begin
            tx_ready = vecs[i].ready;
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk_rd) chk({vecs[i].name, ".rdata"}, data_sram_rdata, vecs[i].exp_rdata);
            chk({vecs[i].name, ".led"}, {16'h0, led}, {16'h0, vecs[i].exp_led});
            chk({vecs[i].name, ".valid"}, {31'h0, tx_valid}, {31'h0, vecs[i].exp_valid});
            chk({vecs[i].name, ".data"}, {24'h0, tx_data}, {24'h0, vecs[i].exp_data});
            tick();
        end

        // Full FIFO with simultaneous push and pop
        tx_ready = 1'b0;
        for (int unsigned b = 0; b < 4; b++) begin
            drive(1'b1, A_TXDATA, 32'h51 + b);
            tick();
        end
        tx_ready = 1'b1;
        drive(1'b1, A_TXDATA, 32'h55);
        chk("pp_head", {24'h0, tx_data}, 32'h51);
        tick();
        drive(1'b0, A_TXSTAT, '0);
        chk("pp_stat", data_sram_rdata, 32'h14);
        for (int unsigned b = 0; b < 4; b++) begin
            chk("pp_order", {24'h0, tx_data}, 32'h52 + b);
            tick();
        end
        chk("pp_empty", {31'h0, tx_valid}, 32'h0);

        // Reset mid-stream
        tx_ready = 1'b0;
        drive(1'b1, A_TXDATA, 32'h61); tick();
        drive(1'b1, A_TXDATA, 32'h62); tick();
        drive(1'b0, A_TXSTAT, '0);
        chk("rst_pre_stat", data_sram_rdata, 32'h02);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, A_TXSTAT, '0);
        chk("rst_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_stat", data_sram_rdata, 32'h08);
        chk("rst_led", {16'h0, led}, 32'h0);
        drive(1'b0, A_RAM, '0);
        chk("rst_ram", data_sram_rdata, 32'h12345678);
        drive(1'b0, A_SCRATCH, '0);
        chk("rst_scratch", data_sram_rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
